// File: rtl/sigen_pulse_gen_if.sv
// Control/status bundle of the multi-channel trigger pulse generator.
// Channel n occupies [n*CNT_W +: CNT_W] in the config buses and [n*MISS_W +: MISS_W] in missed_count.
interface sigen_pulse_gen_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MISS_W   = 8
);
  logic [CHANNELS-1:0]        trigger_input;
  logic [CHANNELS-1:0]        enable;
  logic [CHANNELS-1:0]        retrig_mode;
  logic [CHANNELS*CNT_W-1:0]  delay_cfg;
  logic [CHANNELS*CNT_W-1:0]  width_cfg;
  logic                       count_clear;
  logic [CHANNELS-1:0]        trigger_output;
  logic [CHANNELS-1:0]        busy;
  logic [CHANNELS*MISS_W-1:0] missed_count;

  modport master (
    output trigger_input, enable, retrig_mode, delay_cfg, width_cfg, count_clear,
    input  trigger_output, busy, missed_count
  );

  modport slave (
    input  trigger_input, enable, retrig_mode, delay_cfg, width_cfg, count_clear,
    output trigger_output, busy, missed_count
  );
endinterface

// File: rtl/sigen_pulse_gen.sv
// Multi-channel trigger pulse generator: synchronise, edge-detect, delay, then emit a pulse
// of programmable width; one-shot or retriggerable, with a saturating dropped-trigger count.
module sigen_pulse_gen #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MISS_W      = 8
) (
  input logic              clock,
  input logic              reset,
  sigen_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  logic [CHANNELS-1:0]        trig_out;
  logic [CHANNELS-1:0]        busy_out;
  logic [CHANNELS*MISS_W-1:0] miss_out;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       dly_q, dly_d;
    logic [CNT_W-1:0]       wid_q, wid_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   rise_c;
    logic                   miss_inc_c;
    logic [CNT_W-1:0]       dly_cfg_c, wid_cfg_c;

    assign dly_cfg_c = bus.delay_cfg[ch*CNT_W +: CNT_W];
    assign wid_cfg_c = bus.width_cfg[ch*CNT_W +: CNT_W];
    assign rise_c    = sync_q[SYNC_STAGES-1] & ~last_q;

    // Shadow registers dly_q/wid_q hold the config for the pulse in flight.
    always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], bus.trigger_input[ch]};
      last_d     = sync_q[SYNC_STAGES-1];
      state_d    = state_q;
      cnt_d      = cnt_q;
      dly_d      = dly_q;
      wid_d      = wid_q;
      miss_d     = miss_q;
      miss_inc_c = 1'b0;

      if (!bus.enable[ch]) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise_c && (wid_cfg_c != CNT_ZERO)) begin
              dly_d = dly_cfg_c;
              wid_d = wid_cfg_c;
              if (dly_cfg_c == CNT_ZERO) begin
                state_d = PULSE;
                cnt_d   = wid_cfg_c;
              end else begin
                state_d = DELAY;
                cnt_d   = dly_cfg_c;
              end
            end
          end
          DELAY: begin
            if (rise_c && bus.retrig_mode[ch]) begin
              cnt_d = dly_q;
            end else begin
              miss_inc_c = rise_c;
              if (cnt_q == CNT_ONE) begin
                state_d = PULSE;
                cnt_d   = wid_q;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
          end
          PULSE: begin
            if (rise_c && bus.retrig_mode[ch]) begin
              cnt_d = wid_q;
            end else begin
              miss_inc_c = rise_c;
              if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // Clear wins over a same-cycle increment.
      if (bus.count_clear) begin
        miss_d = '0;
      end else if (miss_inc_c && (miss_q != MISS_MAX)) begin
        miss_d = miss_q + MISS_ONE;
      end

      out_d  = (state_d == PULSE);
      busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q  <= '0;
        last_q  <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
        dly_q   <= '0;
        wid_q   <= '0;
        miss_q  <= '0;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        last_q  <= last_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dly_q   <= dly_d;
        wid_q   <= wid_d;
        miss_q  <= miss_d;
        out_q   <= out_d;
        busy_q  <= busy_d;
      end
    end

    assign trig_out[ch]                   = out_q;
    assign busy_out[ch]                   = busy_q;
    assign miss_out[ch*MISS_W +: MISS_W]  = miss_q;
  end

  assign bus.trigger_output = trig_out;
  assign bus.busy           = busy_out;
  assign bus.missed_count   = miss_out;

endmodule
